// File: rtl/vector_predicate_mask_if.sv
// Predicate, element and writeback bundle for vector_predicate_mask.
// mask_count is only present when VPM_POPCOUNT_EN is defined.
interface vector_predicate_mask_if #(
  parameter int VLEN  = 8,
  parameter int WIDTH = 32
);
  logic             pred_valid;
  logic             pred_ready;
  logic             pred_bit;
  logic             pred_last;
  logic [VLEN-1:0]  mask;
  logic             mask_valid;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_we;
`ifdef VPM_POPCOUNT_EN
  logic [$clog2(VLEN+1)-1:0] mask_count;
`endif

  modport slave (
    input  pred_valid, pred_bit, pred_last,
    input  in_valid, in_data, in_last, out_ready,
    output pred_ready, mask, mask_valid,
    output in_ready, out_valid, out_data, out_we
`ifdef VPM_POPCOUNT_EN
    , output mask_count
`endif
  );

  modport master (
    output pred_valid, pred_bit, pred_last,
    output in_valid, in_data, in_last, out_ready,
    input  pred_ready, mask, mask_valid,
    input  in_ready, out_valid, out_data, out_we
`ifdef VPM_POPCOUNT_EN
    , input mask_count
`endif
  );
endinterface

// File: rtl/vector_predicate_mask.sv
// Packs a 1-bit predicate stream into a lane mask, then tags each element with out_we = mask[lane].
// Optional feature macro: VPM_POPCOUNT_EN adds a registered popcount of the mask (mask_count).
module vector_predicate_mask #(
  parameter int VLEN  = 8,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  vector_predicate_mask_if.slave  bus
);
  localparam int              IDXW      = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam logic [IDXW-1:0] LAST_LANE = IDXW'(VLEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    APPLY   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [VLEN-1:0]  mask_reg, mask_next;
  logic [IDXW-1:0]  wr_idx_reg, wr_idx_next;
  logic [IDXW-1:0]  rd_idx_reg, rd_idx_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_we_reg, out_we_next;

  logic pred_ready;
  logic in_ready;
  logic pred_acc;
  logic in_acc;
  logic clear_lanes;

  assign pred_ready = (state_reg != APPLY);
  assign in_ready   = (state_reg == APPLY) && (!out_valid_reg || bus.out_ready);
  // Anything handed over alongside flush is discarded.
  assign pred_acc   = bus.pred_valid && pred_ready && !flush;
  assign in_acc     = bus.in_valid && in_ready && !flush;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, COLLECT: begin
        if (pred_acc) begin
          state_next = (bus.pred_last || wr_idx_reg == LAST_LANE) ? APPLY : COLLECT;
        end
      end
      APPLY: begin
        if (in_acc && (bus.in_last || rd_idx_reg == LAST_LANE)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // Returning to IDLE wipes the mask so lanes never written read as masked off.
  assign clear_lanes = flush || (state_reg == APPLY && state_next == IDLE);

  for (genvar gi = 0; gi < VLEN; gi++) begin : g_lane
    assign mask_next[gi] = clear_lanes ? 1'b0 :
                           (pred_acc && wr_idx_reg == IDXW'(gi)) ? bus.pred_bit :
                           mask_reg[gi];
  end

  always_comb begin
    wr_idx_next = wr_idx_reg;
    rd_idx_next = rd_idx_reg;
    if (clear_lanes) begin
      wr_idx_next = '0;
      rd_idx_next = '0;
    end else begin
      if (pred_acc && wr_idx_reg != LAST_LANE) begin
        wr_idx_next = wr_idx_reg + IDXW'(1);
      end
      if (in_acc && rd_idx_reg != LAST_LANE) begin
        rd_idx_next = rd_idx_reg + IDXW'(1);
      end
    end
  end

  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_we_next    = out_we_reg;
    if (flush) begin
      out_valid_next = 1'b0;
    end else if (in_acc) begin
      out_valid_next = 1'b1;
      out_data_next  = bus.in_data;
      out_we_next    = mask_reg[rd_idx_reg];
    end else if (bus.out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mask_reg      <= '0;
      wr_idx_reg    <= '0;
      rd_idx_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_we_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mask_reg      <= mask_next;
      wr_idx_reg    <= wr_idx_next;
      rd_idx_reg    <= rd_idx_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_we_reg    <= out_we_next;
    end
  end

`ifdef VPM_POPCOUNT_EN
  localparam int CNTW = $clog2(VLEN + 1);
  logic [CNTW-1:0] count_reg, count_next;

  // Every lane is written once from zero, so counting set bits on accept tracks the popcount.
  always_comb begin
    count_next = count_reg;
    if (clear_lanes) begin
      count_next = '0;
    end else if (pred_acc && bus.pred_bit) begin
      count_next = count_reg + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign bus.mask_count = count_reg;
`endif

  assign bus.pred_ready = pred_ready;
  assign bus.in_ready   = in_ready;
  assign bus.mask       = mask_reg;
  assign bus.mask_valid = (state_reg == APPLY);
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.out_we     = out_we_reg;
endmodule

// File: tb/tb_vector_predicate_mask.sv
// Self-checking bench for vector_predicate_mask: directed scenarios plus randomized vectors
// checked against a lane-list reference model. Honours VPM_POPCOUNT_EN when defined.
module tb_vector_predicate_mask;
  localparam int VLEN  = 8;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: the predicate bits of the current vector, lane by lane.
  bit pbits[VLEN];
  int plen = 0;

  vector_predicate_mask_if #(.VLEN(VLEN), .WIDTH(WIDTH)) bus ();

  vector_predicate_mask #(.VLEN(VLEN), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [VLEN-1:0] model_mask();
    int unsigned acc = 0;
    for (int i = 0; i < plen; i++) if (pbits[i]) acc += (32'd1 << i);
    return VLEN'(acc);
  endfunction

  function automatic logic model_we(input int lane);
    return (lane < plen) ? pbits[lane] : 1'b0;
  endfunction

  function automatic int model_pop();
    int c = 0;
    for (int i = 0; i < plen; i++) c += int'(pbits[i]);
    return c;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic put_pred(input logic b, input logic last);
    bus.pred_valid = 1'b1;
    bus.pred_bit   = b;
    bus.pred_last  = last;
    cycle();
    bus.pred_valid = 1'b0;
    bus.pred_last  = 1'b0;
  endtask

  task automatic put_elem(input logic [WIDTH-1:0] d, input logic last);
    int waitc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    #1;
    while (!bus.in_ready && waitc < 50) begin
      @(posedge clk);
      #2;
      waitc++;
    end
    if (waitc >= 50) begin
      checks++; errors++;
      $display("FAIL elem_timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
    cycle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.mask_valid !== 1'b0) begin errors++; $display("FAIL rst_async_mask_valid: got %b required 0", bus.mask_valid); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_out_valid: got %b required 0", bus.out_valid); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    checks++; if (bus.mask !== 8'h00) begin errors++; $display("FAIL rst_mask: got %h required 00", bus.mask); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h required 0", bus.out_data); end
    checks++; if (bus.out_we !== 1'b0) begin errors++; $display("FAIL rst_out_we: got %b required 0", bus.out_we); end
    checks++; if (bus.pred_ready !== 1'b1) begin errors++; $display("FAIL rst_pred_ready: got %b required 1", bus.pred_ready); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", bus.in_ready); end
`ifdef VPM_POPCOUNT_EN
    checks++; if (bus.mask_count !== 4'd0) begin errors++; $display("FAIL rst_mask_count: got %0d required 0", bus.mask_count); end
`endif
    $display("reset: mask=%h mask_valid=%b out_valid=%b", bus.mask, bus.mask_valid, bus.out_valid);
  endtask

  task automatic test_full_vector();
    int pat[VLEN] = '{1, 0, 1, 1, 0, 0, 1, 0};
    for (int i = 0; i < VLEN; i++) begin
      put_pred(pat[i][0], 1'b0);
      if (i < VLEN - 1) begin
        checks++; if (bus.mask_valid !== 1'b0) begin errors++; $display("FAIL full_early_mask_valid lane %0d: got %b required 0", i, bus.mask_valid); end
      end
    end
    checks++; if (bus.mask !== 8'h4D) begin errors++; $display("FAIL full_mask: got %h required 4d", bus.mask); end
    checks++; if (bus.mask_valid !== 1'b1) begin errors++; $display("FAIL full_mask_valid: got %b required 1", bus.mask_valid); end
`ifdef VPM_POPCOUNT_EN
    checks++; if (bus.mask_count !== 4'd4) begin errors++; $display("FAIL full_mask_count: got %0d required 4", bus.mask_count); end
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < VLEN; i++) begin
      put_elem(WIDTH'(i), 1'b0);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== WIDTH'(i) || bus.out_we !== pat[i][0])
        begin errors++; $display("FAIL full_elem %0d: got v=%b d=%h we=%b required v=1 d=%h we=%b", i, bus.out_valid, bus.out_data, bus.out_we, i, pat[i][0]); end
      $display("full lane %0d: data=%h we=%b", i, bus.out_data, bus.out_we);
    end
    checks++; if (bus.mask_valid !== 1'b0 || bus.mask !== 8'h00) begin errors++; $display("FAIL full_exit: got mask_valid=%b mask=%h required 0/00", bus.mask_valid, bus.mask); end
    cycle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_drain: got out_valid=%b required 0", bus.out_valid); end
`ifdef VPM_POPCOUNT_EN
    checks++; if (bus.mask_count !== 4'd0) begin errors++; $display("FAIL full_idle_mask_count: got %0d required 0", bus.mask_count); end
`endif
  endtask

  task automatic test_short_vector();
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 3; i++) put_pred(1'b1, i == 2);
    checks++; if (bus.mask !== 8'h07 || bus.mask_valid !== 1'b1) begin errors++; $display("FAIL short_mask: got %h/%b required 07/1", bus.mask, bus.mask_valid); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      put_elem(d, i == 2);
      checks++; if (bus.out_data !== d || bus.out_we !== 1'b1) begin errors++; $display("FAIL short_elem %0d: got d=%h we=%b required d=%h we=1", i, bus.out_data, bus.out_we, d); end
    end
    checks++; if (bus.mask_valid !== 1'b0 || bus.pred_ready !== 1'b1) begin errors++; $display("FAIL short_idle: got mask_valid=%b pred_ready=%b required 0/1", bus.mask_valid, bus.pred_ready); end
    // A single-bit vector must land in lane 0 if the counters were cleared.
    put_pred(1'b1, 1'b1);
    checks++; if (bus.mask !== 8'h01 || bus.mask_valid !== 1'b1) begin errors++; $display("FAIL short_restart: got %h/%b required 01/1", bus.mask, bus.mask_valid); end
    put_elem(32'hA5A5_0001, 1'b1);
    checks++; if (bus.out_we !== 1'b1 || bus.mask_valid !== 1'b0) begin errors++; $display("FAIL short_single: got we=%b mask_valid=%b required 1/0", bus.out_we, bus.mask_valid); end
    cycle();
    $display("short: done mask=%h", bus.mask);
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] a, b;
    a = $urandom; b = $urandom;
    plen = VLEN;
    for (int i = 0; i < VLEN; i++) begin
      pbits[i] = 1'($urandom_range(0, 1));
      put_pred(pbits[i], 1'b0);
    end
    checks++; if (bus.mask !== model_mask()) begin errors++; $display("FAIL bp_mask: got %h required %h", bus.mask, model_mask()); end
    bus.out_ready = 1'b0;
    put_elem(a, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = b; bus.in_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== a || bus.out_we !== model_we(0) || bus.in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold %0d: got v=%b d=%h we=%b in_ready=%b required 1/%h/%b/0", k, bus.out_valid, bus.out_data, bus.out_we, bus.in_ready, a, model_we(0)); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got in_ready=%b required 1", bus.in_ready); end
    cycle();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    checks++; if (bus.out_data !== b || bus.out_we !== model_we(1) || bus.mask_valid !== 1'b0)
      begin errors++; $display("FAIL bp_second: got d=%h we=%b mask_valid=%b required %h/%b/0", bus.out_data, bus.out_we, bus.mask_valid, b, model_we(1)); end
    // While the last element waits, a new vector may already start.
    bus.out_ready = 1'b0;
    bus.pred_valid = 1'b1; bus.pred_bit = 1'b1; bus.pred_last = 1'b0;
    #1;
    checks++; if (bus.pred_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_pred_ready: got %b required 1", bus.pred_ready); end
    cycle();
    bus.pred_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== b || bus.mask !== 8'h01)
      begin errors++; $display("FAIL bp_drain: got v=%b d=%h mask=%h required 1/%h/01", bus.out_valid, bus.out_data, bus.mask, b); end
    bus.out_ready = 1'b1;
    cycle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got out_valid=%b required 0", bus.out_valid); end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    $display("backpressure: a=%h b=%h", a, b);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) put_pred(1'b1, 1'b0);
    bus.pred_valid = 1'b1; bus.pred_bit = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0; bus.pred_valid = 1'b0;
    checks++; if (bus.mask !== 8'h00 || bus.mask_valid !== 1'b0) begin errors++; $display("FAIL flush_collect: got mask=%h mask_valid=%b required 00/0", bus.mask, bus.mask_valid); end
    plen = 1; pbits[0] = 1'b1;
    put_pred(1'b1, 1'b1);
    checks++; if (bus.mask !== model_mask()) begin errors++; $display("FAIL flush_restart: got %h required %h", bus.mask, model_mask()); end
    bus.out_ready = 1'b0;
    put_elem(32'h1234_5678, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_we !== 1'b1) begin errors++; $display("FAIL flush_apply_elem: got v=%b we=%b required 1/1", bus.out_valid, bus.out_we); end
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hDEAD_BEEF;
    flush = 1'b1;
    cycle();
    flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.mask_valid !== 1'b0 || bus.mask !== 8'h00 || bus.pred_ready !== 1'b1)
      begin errors++; $display("FAIL flush_apply: got v=%b mv=%b mask=%h pr=%b required 0/0/00/1", bus.out_valid, bus.mask_valid, bus.mask, bus.pred_ready); end
    $display("flush: mask=%h out_valid=%b", bus.mask, bus.out_valid);
  endtask

  task automatic test_async_reset();
    put_pred(1'b1, 1'b0);
    put_pred(1'b0, 1'b1);
    bus.out_ready = 1'b0;
    put_elem(32'hCAFE_0000, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.mask_valid !== 1'b1) begin errors++; $display("FAIL areset_setup: got v=%b mv=%b required 1/1", bus.out_valid, bus.mask_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.mask_valid !== 1'b0 || bus.mask !== 8'h00 || bus.out_data !== 32'h0)
      begin errors++; $display("FAIL areset: got v=%b mv=%b mask=%h d=%h required 0/0/00/0", bus.out_valid, bus.mask_valid, bus.mask, bus.out_data); end
    cycle();
    rst_n = 1'b1;
    cycle();
    checks++; if (bus.pred_ready !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL areset_idle: got pr=%b ir=%b required 1/0", bus.pred_ready, bus.in_ready); end
    $display("async reset: out_valid=%b mask_valid=%b", bus.out_valid, bus.mask_valid);
  endtask

  task automatic test_random();
    logic [WIDTH:0] sb[$];
    logic [WIDTH:0] held_val;
    logic           held;
    int             n, m, sent, cyc, gap;
    for (int v = 0; v < 30; v++) begin
      n = $urandom_range(1, VLEN);
      plen = n;
      for (int i = 0; i < n; i++) begin
        pbits[i] = 1'($urandom_range(0, 1));
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          bus.pred_valid = 1'b0; bus.in_valid = 1'b1; bus.in_data = $urandom;
          #1;
          checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rnd_collect_in_ready: got %b required 0", bus.in_ready); end
          cycle();
        end
        bus.in_valid = 1'b0;
        bus.pred_valid = 1'b1; bus.pred_bit = pbits[i];
        bus.pred_last = (i == n - 1) && (n < VLEN || $urandom_range(0, 1) == 1);
        #1;
        checks++; if (bus.mask_valid !== 1'b0) begin errors++; $display("FAIL rnd_early_mask_valid: got %b required 0", bus.mask_valid); end
        cycle();
      end
      bus.pred_valid = 1'b0; bus.pred_last = 1'b0;
      checks++; if (bus.mask !== model_mask() || bus.mask_valid !== 1'b1)
        begin errors++; $display("FAIL rnd_mask vec %0d: got %h/%b required %h/1", v, bus.mask, bus.mask_valid, model_mask()); end
`ifdef VPM_POPCOUNT_EN
      checks++; if (bus.mask_count !== 4'(model_pop())) begin errors++; $display("FAIL rnd_mask_count vec %0d: got %0d required %0d", v, bus.mask_count, model_pop()); end
`endif
      m = $urandom_range(1, VLEN);
      sent = 0; cyc = 0; held = 1'b0; held_val = '0;
      sb.delete();
      while ((sent < m || sb.size() > 0) && cyc < 400) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        if (sent < m && $urandom_range(0, 3) != 0) begin
          bus.in_valid = 1'b1; bus.in_data = $urandom;
          bus.in_last = (sent == m - 1) && (m < VLEN || $urandom_range(0, 1) == 1);
        end else begin
          bus.in_valid = 1'b0; bus.in_last = 1'b0;
        end
        bus.pred_valid = bus.mask_valid && ($urandom_range(0, 1) == 1);
        #1;
        if (held) begin
          checks++; if (bus.out_valid !== 1'b1 || {bus.out_we, bus.out_data} !== held_val)
            begin errors++; $display("FAIL rnd_hold: got v=%b %h required 1/%h", bus.out_valid, {bus.out_we, bus.out_data}, held_val); end
        end
        if (bus.pred_valid) begin
          checks++; if (bus.pred_ready !== 1'b0) begin errors++; $display("FAIL rnd_apply_pred_ready: got %b required 0", bus.pred_ready); end
        end
        held = bus.out_valid && !bus.out_ready;
        held_val = {bus.out_we, bus.out_data};
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++; $display("FAIL rnd_spurious_out: got %h required none", {bus.out_we, bus.out_data});
          end else begin
            if ({bus.out_we, bus.out_data} !== sb[0]) begin errors++; $display("FAIL rnd_out: got %h required %h", {bus.out_we, bus.out_data}, sb[0]); end
            void'(sb.pop_front());
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          sb.push_back({model_we(sent), bus.in_data});
          sent++;
        end
        cycle();
        cyc++;
      end
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.pred_valid = 1'b0; bus.out_ready = 1'b0;
      if (cyc >= 400) begin
        checks++; errors++;
        $display("FAIL rnd_timeout vec %0d: sent %0d of %0d, %0d pending", v, sent, m, sb.size());
      end
      checks++; if (bus.mask_valid !== 1'b0 || bus.mask !== 8'h00)
        begin errors++; $display("FAIL rnd_exit vec %0d: got %b/%h required 0/00", v, bus.mask_valid, bus.mask); end
`ifdef VPM_POPCOUNT_EN
      checks++; if (bus.mask_count !== 4'd0) begin errors++; $display("FAIL rnd_idle_mask_count: got %0d required 0", bus.mask_count); end
`endif
      $display("random vec %0d: preds=%0d elems=%0d mask=%h", v, n, m, model_mask());
    end
  endtask

  initial begin
    bus.pred_valid = 1'b0; bus.pred_bit = 1'b0; bus.pred_last = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_full_vector();
    test_short_vector();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
